// File: rtl/fc_layer_sequencer_if.sv
// fc_layer_sequencer_if: CPU slave, dot master and result-memory master buses plus done
interface fc_layer_sequencer_if;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        dot_waitrequest;
  logic [3:0]  dot_address;
  logic        dot_read;
  logic        dot_write;
  logic [31:0] dot_readdata;
  logic [31:0] dot_writedata;
  logic        mem_waitrequest;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        done;
  modport slave (
    output slave_waitrequest, slave_readdata, dot_address, dot_read, dot_write, dot_writedata,
           mem_address, mem_write, mem_writedata, done,
    input  slave_address, slave_read, slave_write, slave_writedata, dot_waitrequest, dot_readdata,
           mem_waitrequest
  );
  modport master (
    input  slave_waitrequest, slave_readdata, dot_address, dot_read, dot_write, dot_writedata,
           mem_address, mem_write, mem_writedata, done,
    output slave_address, slave_read, slave_write, slave_writedata, dot_waitrequest, dot_readdata,
           mem_waitrequest
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: runs one dot engine over every output row of an FC layer; FC_RELU_EN clamps negatives
module fc_layer_sequencer (
  input logic clk,
  input logic rst,
  fc_layer_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, CFG_W = 3'd1, CFG_A = 3'd2, CFG_L = 3'd3,
                         KICK = 3'd4, RESULT = 3'd5, STORE = 3'd6, NEXT = 3'd7;
  logic [2:0] state;
  logic [31:0] w_base, a_base, o_base, n_in, n_out, stride, row_addr, j, rows_done, result, clamped;
  logic done_sticky, pulse, busy, last, dw, unused_rd;
  assign busy = state != IDLE;
  assign last = j + 32'd1 >= n_out;
  assign dw = bus.dot_waitrequest;
  assign unused_rd = bus.slave_read;
  assign bus.slave_waitrequest = 1'b0;
  assign bus.done = pulse;
`ifdef FC_RELU_EN
  assign clamped = bus.dot_readdata[31] ? 32'd0 : bus.dot_readdata;
`else
  assign clamped = bus.dot_readdata;
`endif
  // a zero-length row never reaches the dot engine
  assign bus.dot_write = (state == CFG_W && n_in != 0) || state == CFG_A || state == CFG_L || state == KICK;
  assign bus.dot_read = state == RESULT;
  assign bus.mem_write = state == STORE;
  always_comb begin
    bus.dot_address = (state == CFG_W && bus.dot_write) ? 4'd2 : state == CFG_A ? 4'd3 :
                      state == CFG_L ? 4'd5 : state == RESULT ? 4'd1 : 4'd0;
    bus.dot_writedata = (state == CFG_W && bus.dot_write) ? row_addr : state == CFG_A ? a_base :
                        state == CFG_L ? n_in : 32'd0;
    bus.mem_address = bus.mem_write ? o_base + (j << 2) : 32'd0;
    bus.mem_writedata = bus.mem_write ? result : 32'd0;
    case (bus.slave_address)
      4'd0: bus.slave_readdata = {30'd0, done_sticky, busy};
      4'd1: bus.slave_readdata = rows_done;
      4'd2: bus.slave_readdata = w_base;
      4'd3: bus.slave_readdata = a_base;
      4'd4: bus.slave_readdata = o_base;
      4'd5: bus.slave_readdata = n_in;
      4'd6: bus.slave_readdata = n_out;
      4'd7: bus.slave_readdata = result;
      default: bus.slave_readdata = 32'd0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {w_base, a_base, o_base, n_in, n_out} <= '0;
      {stride, row_addr, j, rows_done, result} <= '0;
      done_sticky <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: if (bus.slave_write)
          case (bus.slave_address)
            4'd0: begin
              stride <= n_in << 2;
              row_addr <= w_base;
              j <= 32'd0;
              done_sticky <= n_out == 0;
              pulse <= n_out == 0;
              state <= n_out == 0 ? IDLE : CFG_W;
            end
            4'd2: w_base <= bus.slave_writedata;
            4'd3: a_base <= bus.slave_writedata;
            4'd4: o_base <= bus.slave_writedata;
            4'd5: n_in <= bus.slave_writedata;
            4'd6: n_out <= bus.slave_writedata;
            default: ;
          endcase
        CFG_W: if (n_in == 0) begin
          result <= 32'd0;
          state <= STORE;
        end else if (!dw) state <= CFG_A;
        CFG_A: if (!dw) state <= CFG_L;
        CFG_L: if (!dw) state <= KICK;
        KICK: if (!dw) state <= RESULT;
        RESULT: if (!dw) begin
          result <= clamped;
          state <= STORE;
        end
        STORE: if (!bus.mem_waitrequest) state <= NEXT;
        NEXT: begin
          j <= j + 32'd1;
          row_addr <= row_addr + stride;
          rows_done <= j + 32'd1;
          pulse <= last;
          done_sticky <= done_sticky | last;
          state <= last ? IDLE : CFG_W;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: random FC layers against a matrix-level reference, with bus-emulated dot and memory
module tb_fc_layer_sequencer;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  fc_layer_sequencer_if bus();
  fc_layer_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0, bad = 0;
  logic [31:0] mem [0:255];
  int wt [0:7][0:7];
  int at [0:7];
  logic [63:0] wq[$];
  int fixed_stall = -1, done_cnt = 0, dot_cnt = 0, mem_cnt = 0;
  logic [31:0] rw, ra, rl, da, dd, ma, md;
  logic drd;
  int dk, mk, dacc, macc;
  localparam logic [31:0] WB = 32'h100, AB = 32'h200, OB = 32'h300;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    return fixed_stall >= 0 ? fixed_stall : int'($urandom_range(0, 2));
  endfunction

  function automatic logic [31:0] dot_calc();
    longint s = 0;
    for (int i = 0; i < int'(rl); i++)
      s += (longint'($signed(mem[((rw >> 2) + i) & 255])) * longint'($signed(mem[((ra >> 2) + i) & 255]))) >>> 16;
    return s[31:0];
  endfunction

  function automatic logic [31:0] ref_row(int jj, int ni);
    longint s = 0;
    logic [31:0] r;
    for (int i = 0; i < ni; i++) s += (longint'(wt[jj][i]) * longint'(at[i])) >>> 16;
    r = s[31:0];
`ifdef FC_RELU_EN
    if (r[31]) r = 32'd0;
`endif
    return r;
  endfunction

  initial begin
    bus.dot_waitrequest = 0;
    bus.mem_waitrequest = 0;
    bus.dot_readdata = 0;
    dacc = 0;
    macc = 0;
    forever begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.mem_write) mem_cnt++;
      if (bus.dot_read | bus.dot_write) begin
        dot_cnt++;
        check("dot_rw_excl", {31'd0, bus.dot_read & bus.dot_write}, 0);
      end
      if (rst) begin
        dacc = 0;
        macc = 0;
        bus.dot_waitrequest = 0;
        bus.mem_waitrequest = 0;
      end else begin
        if (bus.dot_read | bus.dot_write) begin
          if (dacc == 0) begin
            dacc = 1; dk = pick(); da = {28'd0, bus.dot_address}; dd = bus.dot_writedata; drd = bus.dot_read;
          end else begin
            check("dot_addr_stable", {28'd0, bus.dot_address}, da);
            check("dot_data_stable", bus.dot_writedata, dd);
            check("dot_rd_stable", {31'd0, bus.dot_read}, {31'd0, drd});
          end
          if (dk > 0) begin
            dk--;
            bus.dot_waitrequest = 1;
          end else begin
            bus.dot_waitrequest = 0;
            dacc = 0;
            if (drd) bus.dot_readdata = dot_calc();
            else if (da == 2) rw = dd;
            else if (da == 3) ra = dd;
            else if (da == 5) rl = dd;
          end
        end else bus.dot_waitrequest = 0;
        if (bus.mem_write) begin
          if (macc == 0) begin
            macc = 1; mk = pick(); ma = bus.mem_address; md = bus.mem_writedata;
          end else begin
            check("mem_addr_stable", bus.mem_address, ma);
            check("mem_data_stable", bus.mem_writedata, md);
          end
          if (mk > 0) begin
            mk--;
            bus.mem_waitrequest = 1;
          end else begin
            bus.mem_waitrequest = 0;
            macc = 0;
            wq.push_back({ma, md});
          end
        end else bus.mem_waitrequest = 0;
      end
    end
  end

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    bus.slave_address = a;
    bus.slave_writedata = d;
    bus.slave_write = 1;
    @(negedge clk);
    bus.slave_write = 0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    bus.slave_address = a;
    #1 d = bus.slave_readdata;
  endtask

  task automatic load(int ni, int no, int mode);
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    for (int i = 0; i < ni; i++) begin
      at[i] = mode == 0 ? int'($urandom_range(0, 32'h7FFFF)) - 32'h40000 : 32'h10000;
      mem[(AB >> 2) + i] = at[i];
    end
    for (int jj = 0; jj < no; jj++)
      for (int i = 0; i < ni; i++) begin
        wt[jj][i] = mode == 0 ? int'($urandom_range(0, 32'h7FFFF)) - 32'h40000 :
                    mode == 1 ? (jj * ni + i + 1) << 16 : -32'sh10000;
        mem[((WB >> 2) + jj * ni + i) & 255] = wt[jj][i];
      end
  endtask

  task automatic run_layer(string tag, int ni, int no, bit meddle);
    int d0, dc0, mc0, t;
    logic [31:0] r;
    cpu_write(2, WB); cpu_write(3, AB); cpu_write(4, OB);
    cpu_write(5, ni); cpu_write(6, no);
    wq.delete();
    d0 = done_cnt; dc0 = dot_cnt; mc0 = mem_cnt;
    cpu_write(0, 0);
    if (meddle) begin
      repeat (4) @(negedge clk);
      cpu_write(0, 0);
      cpu_write(2, 32'h40);
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check({tag, "_timeout"}, {31'd0, t >= 5000}, 0);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_nwrites"}, wq.size(), no);
    for (int jj = 0; jj < no && jj < wq.size(); jj++) begin
      check({tag, "_addr"}, wq[jj][63:32], OB + 4 * jj);
      check({tag, "_data"}, wq[jj][31:0], ref_row(jj, ni));
    end
    if (ni == 0 || no == 0) check({tag, "_no_dot"}, dot_cnt - dc0, 0);
    if (no == 0) check({tag, "_no_mem"}, mem_cnt - mc0, 0);
    cpu_read(0, r); check({tag, "_reg0"}, r, 2);
    if (no > 0) begin
      cpu_read(1, r); check({tag, "_reg1"}, r, no);
      cpu_read(7, r); check({tag, "_reg7"}, r, ref_row(no - 1, ni));
    end
    cpu_read(2, r); check({tag, "_wbase"}, r, WB);
  endtask

  initial begin
    logic [31:0] r;
    int t;
    bus.slave_address = 0; bus.slave_read = 0; bus.slave_write = 0; bus.slave_writedata = 0;
    repeat (3) @(negedge clk);
    check("rst_dot", {bus.dot_read, bus.dot_write, bus.mem_write, bus.done}, 0);
    check("rst_addr", bus.mem_address | {28'd0, bus.dot_address} | bus.dot_writedata | bus.mem_writedata, 0);
    cpu_read(0, r); check("rst_reg0", r, 0);
    check("waitreq", {31'd0, bus.slave_waitrequest}, 0);
    rst = 0;
    @(negedge clk);
    load(2, 3, 1);
    run_layer("t1", 2, 3, 0);
    check("t1_row0", wq.size() > 0 ? wq[0][31:0] : 32'hx, 32'h30000);
    check("t1_row2", wq.size() > 2 ? wq[2][31:0] : 32'hx, 32'hB0000);
    cpu_write(6, 0);
    t = done_cnt;
    cpu_write(0, 0);
    check("t2_done_next", {31'd0, bus.done}, 1);
    cpu_read(0, r); check("t2_reg0", r, 2);
    @(negedge clk);
    check("t2_done_drop", {31'd0, bus.done}, 0);
    load(0, 2, 1);
    run_layer("t3", 0, 2, 0);
    fixed_stall = 5;
    load(2, 3, 1);
    run_layer("t4", 2, 3, 0);
    fixed_stall = -1;
    run_layer("t5", 2, 3, 1);
    cpu_write(0, 0);
    t = 0;
    while (!bus.dot_read && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("t5_reach_result", {31'd0, bus.dot_read}, 1);
    rst = 1;
    @(negedge clk);
    check("t5_rst_strobes", {bus.dot_read, bus.dot_write, bus.mem_write, bus.done}, 0);
    check("t5_rst_buses", bus.mem_address | {28'd0, bus.dot_address} | bus.dot_writedata | bus.mem_writedata, 0);
    cpu_read(0, r); check("t5_rst_reg0", r, 0);
    cpu_read(2, r); check("t5_rst_reg2", r, 0);
    rst = 0;
    @(negedge clk);
    load(2, 1, 2);
    run_layer("t6", 2, 1, 0);
`ifdef FC_RELU_EN
    check("t6_relu", wq.size() > 0 ? wq[0][31:0] : 32'hx, 32'h0);
`else
    check("t6_raw", wq.size() > 0 ? wq[0][31:0] : 32'hx, 32'hFFFE0000);
`endif
    for (int n = 0; n < 20; n++) begin
      int ni, no;
      ni = $urandom_range(0, 4);
      no = $urandom_range(0, 4);
      load(ni, no, 0);
      run_layer("rnd", ni, no, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
